// File: rtl/bus16_capture_arbiter.sv
// Execute-stage result-bus receiver: round-robin grant of 8 tristate drivers, settle, sample, queue.
// Push lands TURN+1 edges after the grant edge; a grant is only issued when a FIFO slot is guaranteed.

// Generic show-ahead FIFO; push and pop on the same edge keep count steady.
// Pop when empty is ignored; push when full is dropped unless a pop frees the slot.
module sync_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q;
  logic          pop_ok, push_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem[rd_ptr];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so natural pointer overflow is the modulo wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

module bus16_capture_arbiter #(
  parameter int DEPTH = 4,
  parameter int TURN  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  req,
  output logic [2:0]  drv_sel,
  output logic        drv_en,
  output logic [7:0]  grant,
  output logic [7:0]  ack,
  input  logic [15:0] bus_in,
  input  logic        pop,
  output logic [15:0] dout,
  output logic        empty,
  output logic        full,
  output logic [3:0]  count
);
  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE} state_t;

  localparam logic [1:0] TLOAD = (TURN > 0) ? 2'(TURN - 1) : 2'd0;

  state_t     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] ptr_q, ptr_d;
  logic [1:0] timer_q, timer_d;
  logic       push;

  logic       win_vld;
  logic [2:0] win_idx;
  logic [2:0] cand;
  logic       fifo_pop;
  logic [3:0] occ_after;
  logic       room;

  // Search ptr+1 .. ptr+7, then ptr itself, so the last winner ranks lowest
  always_comb begin
    win_vld = 1'b0;
    win_idx = ptr_q;
    cand    = ptr_q;
    for (int k = 1; k <= 8; k++) begin
      cand = ptr_q + 3'(k);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Room is judged on occupancy after this edge's pop, since no push can land in IDLE
  assign fifo_pop  = pop & ~empty;
  assign occ_after = count - {3'b000, fifo_pop};
  assign room      = (occ_after < 4'(DEPTH));

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    timer_d = timer_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_vld && room) begin
          sel_d   = win_idx;
          ptr_d   = win_idx;
          timer_d = TLOAD;
          state_d = (TURN == 0) ? CAPTURE : SETTLE;
        end
      end
      SETTLE: begin
        if (timer_q == 2'd0) state_d = CAPTURE;
        else                 timer_d = timer_q - 2'd1;
      end
      CAPTURE: begin
        push    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 3'd0;
      ptr_q   <= 3'd7;
      timer_q <= 2'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      timer_q <= timer_d;
    end
  end

  // Everything driven from registered state, so reset kills drv_en without waiting for an edge
  assign drv_sel = sel_q;
  assign drv_en  = (state_q != IDLE);
  assign grant   = drv_en ? (8'b1 << sel_q) : 8'h00;
  assign ack     = (state_q == CAPTURE) ? (8'b1 << sel_q) : 8'h00;

  sync_fifo #(.W(16), .DEPTH(DEPTH), .CW(4)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (bus_in),
    .pop   (pop),
    .dout  (dout),
    .count (count),
    .empty (empty),
    .full  (full)
  );
endmodule

// File: tb/tb_bus16_capture_arbiter.sv
// Bench for bus16_capture_arbiter: spec vectors, corner sequences, then random traffic vs a queue model.
module tb_bus16_capture_arbiter;
  localparam int DEPTH = 4;
  localparam int TURN  = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  req = 8'h00;
  logic        pop = 1'b0;
  logic [15:0] bus_in = 16'h0000;
  logic [2:0]  drv_sel;
  logic        drv_en;
  logic [7:0]  grant, ack;
  logic [15:0] dout;
  logic        empty, full;
  logic [3:0]  count;

  int checks = 0;
  int failures = 0;

  bus16_capture_arbiter #(.DEPTH(DEPTH), .TURN(TURN)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .drv_sel(drv_sel), .drv_en(drv_en),
    .grant(grant), .ack(ack), .bus_in(bus_in), .pop(pop), .dout(dout),
    .empty(empty), .full(full), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: transaction phase counter, RR pointer and a word queue
  int          m_phase;
  int          m_ptr;
  logic [2:0]  m_sel;
  logic [15:0] m_q[$];

  task automatic model_reset();
    m_phase = 0;
    m_ptr   = 7;
    m_sel   = 3'd0;
    m_q.delete();
  endtask

  task automatic model_step();
    bit popped;
    popped = pop && (m_q.size() > 0);
    if (popped) void'(m_q.pop_front());
    if (m_phase == TURN + 1) begin
      m_q.push_back(bus_in);
      m_phase = 0;
    end else if (m_phase > 0) begin
      m_phase++;
    end else if (req != 8'h00 && m_q.size() < DEPTH) begin
      for (int k = 1; k <= 8; k++) begin
        if (req[(m_ptr + k) % 8]) begin
          m_ptr = (m_ptr + k) % 8;
          break;
        end
      end
      m_sel   = 3'(m_ptr);
      m_phase = 1;
    end
  endtask

  task automatic model_compare();
    logic        e_en;
    logic [7:0]  e_grant, e_ack;
    e_en    = (m_phase > 0);
    e_grant = e_en ? (8'b1 << m_sel) : 8'h00;
    e_ack   = (m_phase == TURN + 1) ? (8'b1 << m_sel) : 8'h00;
    chk("rand_ctl", {6'd0, drv_en, drv_sel, grant, ack, count, empty, full},
        {6'd0, e_en, m_sel, e_grant, e_ack, 4'(m_q.size()), m_q.size() == 0, m_q.size() == DEPTH});
    if (m_q.size() > 0) chk("rand_dout", {16'd0, dout}, {16'd0, m_q[0]});
  endtask

  typedef struct {
    logic [7:0]  req;
    logic        pop;
    logic [15:0] bus;
    logic        e_en;
    logic [2:0]  e_sel;
    logic [7:0]  e_grant;
    logic [7:0]  e_ack;
    logic [3:0]  e_cnt;
    logic [15:0] e_dout;
  } vec_t;

  vec_t vecs[7];
  int   rr_exp[4];

  initial begin
    // Expected values are the state just after the edge on which the inputs are applied
    vecs[0] = '{8'hFF, 1'b0, 16'h0000, 1'b1, 3'd0, 8'h01, 8'h00, 4'd0, 16'h0000};
    vecs[1] = '{8'h00, 1'b0, 16'h0000, 1'b1, 3'd0, 8'h01, 8'h01, 4'd0, 16'h0000};
    vecs[2] = '{8'h00, 1'b0, 16'h1111, 1'b0, 3'd0, 8'h00, 8'h00, 4'd1, 16'h1111};
    vecs[3] = '{8'h08, 1'b1, 16'h0000, 1'b1, 3'd3, 8'h08, 8'h00, 4'd0, 16'h0000};
    vecs[4] = '{8'h08, 1'b0, 16'h0000, 1'b1, 3'd3, 8'h08, 8'h08, 4'd0, 16'h0000};
    vecs[5] = '{8'h00, 1'b0, 16'hBEEF, 1'b0, 3'd3, 8'h00, 8'h00, 4'd1, 16'hBEEF};
    vecs[6] = '{8'h00, 1'b0, 16'h0000, 1'b0, 3'd3, 8'h00, 8'h00, 4'd1, 16'hBEEF};
    rr_exp = '{7, 0, 7, 0};

    // Reset held with every driver requesting
    rst_n = 1'b0;
    req   = 8'hFF;
    tick();
    tick();
    chk("rst_drv_en", {31'd0, drv_en}, 32'd0);
    chk("rst_grant", {24'd0, grant}, 32'd0);
    chk("rst_ack", {24'd0, ack}, 32'd0);
    chk("rst_empty_full_cnt", {26'd0, empty, full, count}, {26'd0, 1'b1, 1'b0, 4'd0});
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      req    = vecs[i].req;
      pop    = vecs[i].pop;
      bus_in = vecs[i].bus;
      tick();
      chk($sformatf("vec%0d_en", i), {31'd0, drv_en}, {31'd0, vecs[i].e_en});
      chk($sformatf("vec%0d_sel", i), {29'd0, drv_sel}, {29'd0, vecs[i].e_sel});
      chk($sformatf("vec%0d_grant", i), {24'd0, grant}, {24'd0, vecs[i].e_grant});
      chk($sformatf("vec%0d_ack", i), {24'd0, ack}, {24'd0, vecs[i].e_ack});
      chk($sformatf("vec%0d_count", i), {28'd0, count}, {28'd0, vecs[i].e_cnt});
      if (vecs[i].e_cnt != 4'd0)
        chk($sformatf("vec%0d_dout", i), {16'd0, dout}, {16'd0, vecs[i].e_dout});
    end

    // Round robin between drivers 0 and 7, last winner was 3
    req = 8'h81;
    pop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rr%0d_sel", i), {29'd0, drv_sel}, 32'(rr_exp[i]));
      chk($sformatf("rr%0d_grant", i), {24'd0, grant}, 32'(1 << rr_exp[i]));
      tick();
      chk($sformatf("rr%0d_ack", i), {24'd0, ack}, 32'(1 << rr_exp[i]));
      chk($sformatf("rr%0d_onehot", i), {31'd0, $onehot(grant)}, 32'd1);
      tick();
      chk($sformatf("rr%0d_dead", i), {31'd0, drv_en}, 32'd0);
    end
    req = 8'h00;
    tick();
    chk("rr_drained", {28'd0, count}, 32'd0);

    // Fill the FIFO without popping; the fifth request must stall
    pop = 1'b0;
    req = 8'h08;
    for (int i = 0; i < 4; i++) begin
      bus_in = 16'hA000 + 16'(i);
      tick();
      tick();
      tick();
    end
    bus_in = 16'hA004;
    chk("full_count", {28'd0, count}, 32'd4);
    chk("full_flag", {31'd0, full}, 32'd1);
    tick();
    chk("full_stall_en", {31'd0, drv_en}, 32'd0);
    tick();
    chk("full_stall_en2", {31'd0, drv_en}, 32'd0);
    pop = 1'b1;
    tick();
    chk("full_pop_grant", {24'd0, grant}, 32'h08);
    chk("full_pop_count", {28'd0, count}, 32'd3);
    chk("full_pop_head", {16'd0, dout}, 32'hA001);
    pop = 1'b0;
    req = 8'h00;
    tick();
    tick();
    chk("refill_count", {27'd0, full, count}, {27'd0, 1'b1, 4'd4});

    // Simultaneous push and pop at occupancy 2
    pop = 1'b1;
    tick();
    tick();
    chk("pp_pre_count", {28'd0, count}, 32'd2);
    chk("pp_pre_head", {16'd0, dout}, 32'hA003);
    pop    = 1'b0;
    req    = 8'h08;
    bus_in = 16'hB00B;
    tick();
    tick();
    req = 8'h00;
    pop = 1'b1;
    tick();
    chk("pp_count", {28'd0, count}, 32'd2);
    chk("pp_head", {16'd0, dout}, 32'hA004);
    tick();
    chk("pp_next_head", {16'd0, dout}, 32'hB00B);
    tick();
    tick();
    chk("pop_empty_count", {27'd0, empty, count}, {27'd0, 1'b1, 4'd0});

    // Asynchronous reset in the middle of a settle window
    pop = 1'b0;
    req = 8'h08;
    tick();
    chk("mid_settle_en", {31'd0, drv_en}, 32'd1);
    rst_n = 1'b0;
    req   = 8'h00;
    #1;
    chk("mid_rst_en", {31'd0, drv_en}, 32'd0);
    chk("mid_rst_grant", {24'd0, grant}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("mid_rst_after", {26'd0, empty, drv_en, count}, {26'd0, 1'b1, 1'b0, 4'd0});

    // Random traffic against the reference model
    rst_n = 1'b0;
    req   = 8'h00;
    pop   = 1'b0;
    tick();
    model_reset();
    rst_n = 1'b1;
    model_compare();
    for (int c = 0; c < 3000; c++) begin
      req    = 8'($urandom) & 8'($urandom);
      pop    = ($urandom_range(0, 3) == 0);
      bus_in = 16'($urandom);
      @(posedge clk);
      model_step();
      @(negedge clk);
      model_compare();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
